sample_epoch_trigger: RTL and testbench

- Consumer of the sample-count stream (o_vld/o_count) produced by the tracking sample counter.
- Arms on a command holding a target sample index, optional period and repeat count.
- Emits a one-cycle fire pulse each time the incoming count equals the armed target, for example to trigger a correlator dump or an epoch.
- Flags a late command when the count is already past the target; sits between the sample counter and the tracking-channel control logic.

---
 rtl/sample_epoch_trigger_if.sv | 28 ++
 rtl/sample_epoch_trigger.sv | 92 +++++++++
 tb/tb_sample_epoch_trigger.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sample_epoch_trigger_if.sv
// rtl/sample_epoch_trigger_if.sv - command handshake bundle for the sample epoch trigger
interface sample_epoch_trigger_if #(
    parameter int CNT_W = 64,
    parameter int PER_W = 32,
    parameter int REP_W = 16
);
    logic             s_cmd_valid;
    logic             s_cmd_ready;
    logic [CNT_W-1:0] s_cmd_target;
    logic [PER_W-1:0] s_cmd_period;
    logic [REP_W-1:0] s_cmd_reps;

    modport master (
        output s_cmd_valid,
        output s_cmd_target,
        output s_cmd_period,
        output s_cmd_reps,
        input  s_cmd_ready
    );

    modport slave (
        input  s_cmd_valid,
        input  s_cmd_target,
        input  s_cmd_period,
        input  s_cmd_reps,
        output s_cmd_ready
    );
endinterface

// File: rtl/sample_epoch_trigger.sv
// rtl/sample_epoch_trigger.sv - fires a pulse when the sample count reaches an armed target
module sample_epoch_trigger #(
    parameter int CNT_W = 64,
    parameter int PER_W = 32,
    parameter int REP_W = 16
) (
    input  logic                     axis_aclk,
    input  logic                     axis_aresetn,
    sample_epoch_trigger_if.slave    cmd,
    input  logic                     i_cnt_vld,
    input  logic [CNT_W-1:0]         i_cnt,
    input  logic                     i_abort,
    output logic                     o_fire,
    output logic [CNT_W-1:0]         o_fire_cnt,
    output logic                     o_late,
    output logic                     o_busy,
    output logic [REP_W-1:0]         o_fires,
    output logic [1:0]               o_st
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        BAD2  = 2'b10,
        BAD3  = 2'b11
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] target;
    logic [PER_W-1:0] period;
    logic [REP_W-1:0] remaining;
    logic             cmd_acc;
    logic [CNT_W-1:0] period_ext;

    // The reset term keeps ready low for the whole time reset is asserted.
    assign cmd.s_cmd_ready = (st == IDLE) && !i_abort && !axis_aresetn;
    assign cmd_acc         = cmd.s_cmd_valid && cmd.s_cmd_ready;
    assign period_ext      = {{(CNT_W-PER_W){1'b0}}, period};
    assign o_busy          = (st == ARMED);
    assign o_st            = st;

    always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
        if (axis_aresetn) begin
            st         <= IDLE;
            target     <= '0;
            period     <= '0;
            remaining  <= '0;
            o_fire     <= 1'b0;
            o_late     <= 1'b0;
            o_fire_cnt <= '0;
            o_fires    <= '0;
        end else begin
            o_fire <= 1'b0;
            o_late <= 1'b0;
            case (st)
                IDLE: begin
                    if (cmd_acc) begin
                        target    <= cmd.s_cmd_target;
                        period    <= cmd.s_cmd_period;
                        remaining <= cmd.s_cmd_reps;
                        o_fires   <= '0;
                        st        <= ARMED;
                    end
                end
                ARMED: begin
                    if (i_abort) begin
                        st <= IDLE;
                    end else if (i_cnt_vld) begin
                        if (i_cnt == target) begin
                            o_fire     <= 1'b1;
                            o_fire_cnt <= i_cnt;
                            o_fires    <= o_fires + 1'b1;
                            // remaining==0 means unlimited repeats, so only 1 ends the run
                            if (period == '0 || remaining == {{(REP_W-1){1'b0}}, 1'b1}) begin
                                st <= IDLE;
                            end else begin
                                target <= target + period_ext;
                                if (remaining != '0) begin
                                    remaining <= remaining - 1'b1;
                                end
                            end
                        end else if (i_cnt > target) begin
                            o_late     <= 1'b1;
                            o_fire_cnt <= i_cnt;
                            st         <= IDLE;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_epoch_trigger.sv
// tb/tb_sample_epoch_trigger.sv - directed and randomized checks of sample_epoch_trigger against a reference model
module tb_sample_epoch_trigger;
    localparam int CNT_W = 64;
    localparam int PER_W = 32;
    localparam int REP_W = 16;

    logic             axis_aclk = 1'b0;
    logic             axis_aresetn;
    logic             i_cnt_vld;
    logic [CNT_W-1:0] i_cnt;
    logic             i_abort;
    logic             o_fire;
    logic [CNT_W-1:0] o_fire_cnt;
    logic             o_late;
    logic             o_busy;
    logic [REP_W-1:0] o_fires;
    logic [1:0]       o_st;

    int checks = 0;
    int errors = 0;

    sample_epoch_trigger_if #(.CNT_W(CNT_W), .PER_W(PER_W), .REP_W(REP_W)) cmd_if ();

    sample_epoch_trigger #(.CNT_W(CNT_W), .PER_W(PER_W), .REP_W(REP_W)) dut (
        .axis_aclk    (axis_aclk),
        .axis_aresetn (axis_aresetn),
        .cmd          (cmd_if),
        .i_cnt_vld    (i_cnt_vld),
        .i_cnt        (i_cnt),
        .i_abort      (i_abort),
        .o_fire       (o_fire),
        .o_fire_cnt   (o_fire_cnt),
        .o_late       (o_late),
        .o_busy       (o_busy),
        .o_fires      (o_fires),
        .o_st         (o_st)
    );

    always #5 axis_aclk = ~axis_aclk;

    // Reference model: the schedule of remaining fire points of the armed command.
    bit               m_armed;
    logic [CNT_W-1:0] m_next;
    logic [CNT_W-1:0] m_step;
    int               m_left;      // fires still allowed; -1 = unlimited
    logic [CNT_W-1:0] e_fc;
    logic [REP_W-1:0] e_fires;
    bit               e_fire;
    bit               e_late;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_next = '0; m_step = '0; m_left = 0;
        e_fc = '0; e_fires = '0; e_fire = 0; e_late = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".fire"},  o_fire,     e_fire);
        chk({tag, ".late"},  o_late,     e_late);
        chk({tag, ".fcnt"},  o_fire_cnt, e_fc);
        chk({tag, ".fires"}, o_fires,    e_fires);
        chk({tag, ".busy"},  o_busy,     m_armed);
        chk({tag, ".st"},    o_st,       m_armed ? 2'd1 : 2'd0);
    endtask

    task automatic step(input string tag, input logic vld, input logic [63:0] cnt, input logic abort,
                        input logic cv, input logic [63:0] ct, input logic [31:0] cp, input logic [15:0] cr);
        bit acc;
        @(negedge axis_aclk);
        i_cnt_vld = vld; i_cnt = cnt; i_abort = abort;
        cmd_if.s_cmd_valid = cv; cmd_if.s_cmd_target = ct;
        cmd_if.s_cmd_period = cp; cmd_if.s_cmd_reps = cr;
        #1;
        chk({tag, ".ready"}, cmd_if.s_cmd_ready, !m_armed && !abort);
        acc = cv && !m_armed && !abort;
        e_fire = 0; e_late = 0;
        if (m_armed && abort) begin
            m_armed = 0;
        end else if (m_armed && vld) begin
            if (cnt == m_next) begin
                e_fire = 1; e_fc = cnt; e_fires = e_fires + 1;
                if (m_left > 0) m_left = m_left - 1;
                if (m_step == 0 || m_left == 0) m_armed = 0;
                else m_next = m_next + m_step;
            end else if (cnt > m_next) begin
                e_late = 1; e_fc = cnt; m_armed = 0;
            end
        end
        if (acc) begin
            m_armed = 1; m_next = ct; m_step = {32'd0, cp};
            m_left = (cr == 0) ? -1 : int'(cr);
            e_fires = '0;
        end
        @(posedge axis_aclk);
        #1;
        check_outputs(tag);
    endtask

    task automatic smp(input string tag, input logic vld, input logic [63:0] cnt);
        step(tag, vld, cnt, 1'b0, 1'b0, 64'd0, 32'd0, 16'd0);
    endtask

    task automatic cmd(input string tag, input logic [63:0] t, input logic [31:0] p, input logic [15:0] r);
        step(tag, 1'b0, 64'd0, 1'b0, 1'b1, t, p, r);
    endtask

    initial begin
        logic [63:0] cur;
        logic [63:0] top;
        axis_aresetn = 1'b1;
        i_cnt_vld = 0; i_cnt = '0; i_abort = 0;
        cmd_if.s_cmd_valid = 0; cmd_if.s_cmd_target = '0;
        cmd_if.s_cmd_period = '0; cmd_if.s_cmd_reps = '0;
        model_reset();
        repeat (2) @(posedge axis_aclk);
        #1;
        chk("rst.ready", cmd_if.s_cmd_ready, 1'b0);
        check_outputs("rst");
        @(negedge axis_aclk);
        axis_aresetn = 1'b0;

        // One-shot at 100, samples on every other cycle.
        cmd("t1.cmd", 64'd100, 32'd0, 16'd0);
        for (int c = 95; c <= 105; c++) begin
            smp("t1.s", 1'b1, 64'(c));
            smp("t1.gap", 1'b0, 64'(c));
        end

        // Period 5, three fires over a contiguous run.
        cmd("t2.cmd", 64'd10, 32'd5, 16'd3);
        for (int c = 0; c <= 40; c++) smp("t2.s", 1'b1, 64'(c));

        // Count already past the target.
        cmd("t3.cmd", 64'd50, 32'd0, 16'd0);
        smp("t3.s", 1'b1, 64'd60);

        // Target wraps past 2^64; unlimited repeats, then disarm.
        top = '1;
        cmd("t4.cmd", top - 64'd2, 32'd4, 16'd0);
        for (int k = 4; k >= 2; k--) smp("t4.hi", 1'b1, top - 64'(k));
        for (int c = 0; c <= 2; c++) smp("t4.lo", 1'b1, 64'(c));
        step("t4.abort", 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 32'd0, 16'd0);

        // Abort on the matching sample, with a second command held pending.
        cmd("t5.cmd", 64'd20, 32'd0, 16'd0);
        step("t5.s18", 1'b1, 64'd18, 1'b0, 1'b1, 64'd30, 32'd0, 16'd0);
        step("t5.s19", 1'b1, 64'd19, 1'b0, 1'b1, 64'd30, 32'd0, 16'd0);
        step("t5.abort", 1'b1, 64'd20, 1'b1, 1'b1, 64'd30, 32'd0, 16'd0);
        step("t5.acc", 1'b0, 64'd0, 1'b0, 1'b1, 64'd30, 32'd0, 16'd0);
        smp("t5.s30", 1'b1, 64'd30);

        // Asynchronous reset while armed with one fire already counted.
        cmd("t6.cmd", 64'd40, 32'd10, 16'd0);
        smp("t6.s40", 1'b1, 64'd40);
        @(negedge axis_aclk);
        #2 axis_aresetn = 1'b1;
        #1;
        chk("t6.async.st", o_st, 2'd0);
        chk("t6.async.busy", o_busy, 1'b0);
        chk("t6.async.fires", o_fires, 16'd0);
        model_reset();
        @(negedge axis_aclk);
        axis_aresetn = 1'b0;
        smp("t6.s50", 1'b1, 64'd50);

        // Randomized commands against mostly increasing counts.
        cur = 64'd100;
        for (int n = 0; n < 12; n++) begin
            if (m_armed) step("r.abort", 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 32'd0, 16'd0);
            cmd("r.cmd", cur + 64'($urandom_range(0, 24)) - 64'd3,
                32'($urandom_range(0, 6)), 16'($urandom_range(0, 3)));
            for (int k = 0; k < 40; k++) begin
                logic v;
                v = ($urandom_range(0, 3) != 0);
                if (v) cur = cur + 64'($urandom_range(0, 2));
                step("r.s", v, cur, ($urandom_range(0, 39) == 0), 1'b0, 64'd0, 32'd0, 16'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
